// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the mips_multicycle main controller.
// Holds the FSM state enum, opcode/funct/ALU codes and the per-state control table.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOP_NONE marks states that do not use the ALU; it drives ALUControl to 000.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       halted;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c       = '0;
    c.aluop = ALUOP_NONE;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.aluop   = ALUOP_ADD;
        c.pcwrite = 1'b1;
      end
      S_DECODE: begin
        c.alusrcb = SRCB_IMMSH;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMRD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PCSRC_ALUOUT;
        c.branch  = 1'b1;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JEX: begin
        c.pcsrc   = PCSRC_JUMP;
        c.pcwrite = 1'b1;
      end
      S_HALT:  c.halted = 1'b1;
      default: c.aluop = ALUOP_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_aludec.sv
// ALU decoder: maps the controller's ALUOp and the instruction funct field
// to the 3-bit ALUControl code driven into the datapath ALU.
module mips_mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol
);

  always_comb begin
    o_alucontrol = ALU_ADD;
    case (i_aluop)
      ALUOP_ADD: o_alucontrol = ALU_ADD;
      ALUOP_SUB: o_alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_ADD: o_alucontrol = ALU_ADD;
          FUNCT_SUB: o_alucontrol = ALU_SUB;
          FUNCT_AND: o_alucontrol = ALU_AND;
          FUNCT_OR:  o_alucontrol = ALU_OR;
          FUNCT_SLT: o_alucontrol = ALU_SLT;
          default:   o_alucontrol = ALU_ADD;
        endcase
      end
      default: o_alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Main Moore control FSM of the multicycle MIPS core: sequences fetch, decode
// and per-opcode execute/writeback, and parks in HALT on the halt opcode.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int                OP_WIDTH    = 6,
  parameter int                FUNCT_WIDTH = 6,
  parameter logic [OP_WIDTH-1:0] HALT_OP   = 6'h3F
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_WIDTH-1:0]    Op,
  input  logic [FUNCT_WIDTH-1:0] Funct,
  input  logic                   Zero,
  output logic                   IorD,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [2:0]             ALUControl,
  output logic [1:0]             PCSrc,
  output logic                   PCEn,
  output logic                   Halted
);

  state_t     r_state;
  state_t     w_next;
  ctrl_t      w_ctl_next;
  logic [2:0] w_alucontrol_next;

  logic       r_iord, r_memwrite, r_irwrite, r_regdst, r_memtoreg, r_regwrite;
  logic       r_alusrca, r_pcwrite, r_branch, r_halted;
  logic [1:0] r_alusrcb, r_pcsrc;
  logic [2:0] r_alucontrol;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH: w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          HALT_OP:      w_next = S_HALT;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_FETCH;
    endcase
  end

  // Outputs are registered from the next state so they are valid for the whole state.
  assign w_ctl_next = state_ctrl(w_next);

  mips_mc_aludec u_aludec (
    .i_aluop      (w_ctl_next.aluop),
    .i_funct      (Funct),
    .o_alucontrol (w_alucontrol_next)
  );

  // Reset loads the FETCH selects; the enables are masked below while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_iord       <= 1'b0;
      r_memwrite   <= 1'b0;
      r_irwrite    <= 1'b1;
      r_regdst     <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_regwrite   <= 1'b0;
      r_alusrca    <= 1'b0;
      r_alusrcb    <= SRCB_FOUR;
      r_alucontrol <= ALU_ADD;
      r_pcsrc      <= PCSRC_ALU;
      r_pcwrite    <= 1'b1;
      r_branch     <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_iord       <= w_ctl_next.iord;
      r_memwrite   <= w_ctl_next.memwrite;
      r_irwrite    <= w_ctl_next.irwrite;
      r_regdst     <= w_ctl_next.regdst;
      r_memtoreg   <= w_ctl_next.memtoreg;
      r_regwrite   <= w_ctl_next.regwrite;
      r_alusrca    <= w_ctl_next.alusrca;
      r_alusrcb    <= w_ctl_next.alusrcb;
      r_alucontrol <= w_alucontrol_next;
      r_pcsrc      <= w_ctl_next.pcsrc;
      r_pcwrite    <= w_ctl_next.pcwrite;
      r_branch     <= w_ctl_next.branch;
      r_halted     <= w_ctl_next.halted;
    end
  end

  assign IorD       = r_iord;
  assign MemWrite   = r_memwrite & ~reset;
  assign IRWrite    = r_irwrite & ~reset;
  assign RegDst     = r_regdst;
  assign MemtoReg   = r_memtoreg;
  assign RegWrite   = r_regwrite & ~reset;
  assign ALUSrcA    = r_alusrca;
  assign ALUSrcB    = r_alusrcb;
  assign ALUControl = r_alucontrol;
  assign PCSrc      = r_pcsrc;
  assign PCEn       = (r_pcwrite | (r_branch & Zero)) & ~reset;
  assign Halted     = r_halted;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: per-cycle expected control vectors
// for each instruction class, plus halt and asynchronous-reset sequences.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn, Halted;

  int checks = 0;
  int errors = 0;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn), .Halted(Halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  logic [15:0] w_obs;
  assign w_obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUControl, PCSrc, PCEn, Halted};

  function automatic logic [15:0] pk(input logic iord, mw, irw, rd, mtr, rw, sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [1:0] pcs, input logic pcen, h);
    return {iord, mw, irw, rd, mtr, rw, sa, sb, alu, pcs, pcen, h};
  endfunction

  logic [15:0] E_RST, E_F, E_D, E_MA, E_MR, E_MWB, E_MWR, E_RWB, E_AWB, E_J, E_H;

  function automatic logic [15:0] e_rx(input logic [2:0] alu);
    return pk(0, 0, 0, 0, 0, 0, 1, 2'b00, alu, 2'b00, 0, 0);
  endfunction

  function automatic logic [15:0] e_bx(input logic z);
    return pk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, z, 0);
  endfunction

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic [5:0] op, fn,
                              input logic z, input logic [15:0] exp);
    vec_t v;
    v.nm = nm; v.op = op; v.fn = fn; v.z = z; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] exp);
    checks++;
    if (w_obs !== exp) begin
      errors++;
      $display("FAIL %s got %b required %b", nm, w_obs, exp);
    end
  endtask

  task automatic step(input string nm, input logic [5:0] op, fn,
                      input logic z, input logic [15:0] exp);
    Op = op; Funct = fn; Zero = z;
    @(negedge clk);
    chk(nm, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    E_RST = pk(0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0, 0);
    E_F   = pk(0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0);
    E_D   = pk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0);
    E_MA  = pk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0);
    E_MR  = pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    E_MWB = pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    E_MWR = pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    E_RWB = pk(0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    E_AWB = pk(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
    E_J   = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1, 0);
    E_H   = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1);

    tbl.push_back(mk("lw_fetch",   6'h23, 6'h00, 0, E_F));
    tbl.push_back(mk("lw_decode",  6'h23, 6'h00, 0, E_D));
    tbl.push_back(mk("lw_memadr",  6'h23, 6'h00, 0, E_MA));
    tbl.push_back(mk("lw_memrd",   6'h23, 6'h00, 0, E_MR));
    tbl.push_back(mk("lw_memwb",   6'h23, 6'h00, 0, E_MWB));
    tbl.push_back(mk("sub_fetch",  6'h00, 6'h22, 0, E_F));
    tbl.push_back(mk("sub_decode", 6'h00, 6'h22, 0, E_D));
    tbl.push_back(mk("sub_ex",     6'h00, 6'h22, 0, e_rx(3'b110)));
    tbl.push_back(mk("sub_wb",     6'h00, 6'h22, 0, E_RWB));
    tbl.push_back(mk("slt_fetch",  6'h00, 6'h2A, 0, E_F));
    tbl.push_back(mk("slt_decode", 6'h00, 6'h2A, 0, E_D));
    tbl.push_back(mk("slt_ex",     6'h00, 6'h2A, 0, e_rx(3'b111)));
    tbl.push_back(mk("slt_wb",     6'h00, 6'h2A, 0, E_RWB));
    tbl.push_back(mk("f3f_fetch",  6'h00, 6'h3F, 0, E_F));
    tbl.push_back(mk("f3f_decode", 6'h00, 6'h3F, 0, E_D));
    tbl.push_back(mk("f3f_ex",     6'h00, 6'h3F, 0, e_rx(3'b010)));
    tbl.push_back(mk("f3f_wb",     6'h00, 6'h3F, 0, E_RWB));
    tbl.push_back(mk("beq1_fetch", 6'h04, 6'h00, 1, E_F));
    tbl.push_back(mk("beq1_decode",6'h04, 6'h00, 1, E_D));
    tbl.push_back(mk("beq1_ex",    6'h04, 6'h00, 1, e_bx(1'b1)));
    tbl.push_back(mk("beq0_fetch", 6'h04, 6'h00, 0, E_F));
    tbl.push_back(mk("beq0_decode",6'h04, 6'h00, 0, E_D));
    tbl.push_back(mk("beq0_ex",    6'h04, 6'h00, 0, e_bx(1'b0)));
    tbl.push_back(mk("sw_fetch",   6'h2B, 6'h00, 0, E_F));
    tbl.push_back(mk("sw_decode",  6'h2B, 6'h00, 0, E_D));
    tbl.push_back(mk("sw_memadr",  6'h2B, 6'h00, 0, E_MA));
    tbl.push_back(mk("sw_memwr",   6'h2B, 6'h00, 0, E_MWR));
    tbl.push_back(mk("j_fetch",    6'h02, 6'h00, 0, E_F));
    tbl.push_back(mk("j_decode",   6'h02, 6'h00, 0, E_D));
    tbl.push_back(mk("j_ex",       6'h02, 6'h00, 0, E_J));
    tbl.push_back(mk("addi_fetch", 6'h08, 6'h00, 0, E_F));
    tbl.push_back(mk("addi_decode",6'h08, 6'h00, 0, E_D));
    tbl.push_back(mk("addi_ex",    6'h08, 6'h00, 0, E_MA));
    tbl.push_back(mk("addi_wb",    6'h08, 6'h00, 0, E_AWB));
    tbl.push_back(mk("nop_fetch",  6'h11, 6'h00, 0, E_F));
    tbl.push_back(mk("nop_decode", 6'h11, 6'h00, 0, E_D));

    // Reset held across two edges with a load word pending.
    reset = 1'b1; Op = 6'h23; Funct = 6'h00; Zero = 1'b0;
    @(negedge clk); chk("reset_c0", E_RST);
    @(negedge clk); chk("reset_c1", E_RST);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (tbl[i]) step(tbl[i].nm, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].exp);

    // Halt: park for 20 cycles, then recover through reset.
    step("halt_fetch", 6'h3F, 6'h00, 0, E_F);
    step("halt_decode", 6'h3F, 6'h00, 0, E_D);
    for (int k = 0; k < 20; k++) step($sformatf("halt_hold%0d", k), 6'h3F, 6'h00, k[0], E_H);
    reset = 1'b1;
    #1 chk("halt_reset", E_RST);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); chk("halt_exit_fetch", E_F);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of MEMWB.
    step("mid_fetch", 6'h23, 6'h00, 0, E_D);
    step("mid_memadr", 6'h23, 6'h00, 0, E_MA);
    step("mid_memrd", 6'h23, 6'h00, 0, E_MR);
    @(negedge clk); chk("mid_memwb", E_MWB);
    #1 reset = 1'b1;
    #1 chk("mid_reset_async", E_RST);
    @(posedge clk); #1;
    reset = 1'b0;
    step("undef_fetch", 6'h11, 6'h00, 0, E_F);
    step("undef_decode", 6'h11, 6'h00, 0, E_D);
    step("undef_refetch", 6'h11, 6'h00, 0, E_F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
